// File: rtl/subset_coord_loader.sv
// subset_coord_loader: after param_done rises, reads num_of_subsets packed (x,y)
// subset centres from the shared BRAM, one read in flight at a time, and queues
// them with their table index in a show-ahead FIFO for the correlation engine.
// Optional feature macro: SUBSET_BOUNDS_CHECK_EN. When defined, entries with
// x >= width_ or y >= height_ are dropped and counted. When undefined, every
// entry is queued and err_count/load_err stay 0.
module subset_coord_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        param_done,
    input  logic [31:0] num_of_subsets,
    input  logic [31:0] width_,
    input  logic [31:0] height_,
    output logic [31:0] bram_addr,
    output logic        bram_ea,
    output logic [3:0]  bram_we,
    input  logic [31:0] bram_dout,
    output logic        coord_valid,
    input  logic        coord_ready,
    output logic [15:0] coord_x,
    output logic [15:0] coord_y,
    output logic [31:0] coord_idx,
    output logic        load_done,
    output logic        load_err,
    output logic [31:0] err_count
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = 3;
    // Last WAIT count before CAPTURE; unused when RD_LAT is 1 (WAIT skipped).
    localparam logic [WAIT_W-1:0] WAIT_LAST = (RD_LAT > 1) ? WAIT_W'(RD_LAT - 2) : '0;
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               param_done_q;
    logic [31:0]        count_q, count_d;
    logic [31:0]        idx_q, idx_d;
    logic [31:0]        bram_addr_q, bram_addr_d;
    logic               bram_ea_q, bram_ea_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               load_done_q, load_done_d;
    logic [15:0]        fifo_x_q [FIFO_DEPTH];
    logic [15:0]        fifo_x_d [FIFO_DEPTH];
    logic [15:0]        fifo_y_q [FIFO_DEPTH];
    logic [15:0]        fifo_y_d [FIFO_DEPTH];
    logic [31:0]        fifo_idx_q [FIFO_DEPTH];
    logic [31:0]        fifo_idx_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic               start;
    logic               accept;
    logic               push;
    logic               pop;

`ifdef SUBSET_BOUNDS_CHECK_EN
    logic [31:0]        width_q, width_d;
    logic [31:0]        height_q, height_d;
    logic [31:0]        err_count_q, err_count_d;
    logic               load_err_q, load_err_d;
`else
    logic               unused_dims;
    assign unused_dims = ^{width_, height_};
`endif

    assign start = param_done && !param_done_q;
    assign pop   = coord_valid && coord_ready;

    // Entry acceptance: bounds compare on zero-extended x/y, or accept all.
    always_comb begin
`ifdef SUBSET_BOUNDS_CHECK_EN
        accept = ({16'h0, bram_dout[31:16]} < width_q) &&
                 ({16'h0, bram_dout[15:0]}  < height_q);
`else
        accept = 1'b1;
`endif
    end

    // Sequencer next-state, BRAM control and FIFO update.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        bram_addr_d = bram_addr_q;
        bram_ea_d   = bram_ea_q;
        wait_d      = wait_q;
        load_done_d = load_done_q;
        push        = 1'b0;
        fifo_x_d    = fifo_x_q;
        fifo_y_d    = fifo_y_q;
        fifo_idx_d  = fifo_idx_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
`ifdef SUBSET_BOUNDS_CHECK_EN
        width_d     = width_q;
        height_d    = height_q;
        err_count_d = err_count_q;
        load_err_d  = load_err_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d     = num_of_subsets;
                    idx_d       = '0;
                    bram_addr_d = BASE_ADDR;
                    load_done_d = 1'b0;
`ifdef SUBSET_BOUNDS_CHECK_EN
                    width_d     = width_;
                    height_d    = height_;
                    err_count_d = '0;
                    load_err_d  = 1'b0;
`endif
                    if (num_of_subsets == 32'd0) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (fifo_cnt_q != FIFO_FULL) begin
                    bram_ea_d   = 1'b1;
                    bram_addr_d = BASE_ADDR + {idx_q[29:0], 2'b00};
                    wait_d      = '0;
                    state_d     = (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_CAPTURE: begin
                bram_ea_d = 1'b0;
                idx_d     = idx_q + 32'd1;
                if (accept) begin
                    push = 1'b1;
                end else begin
`ifdef SUBSET_BOUNDS_CHECK_EN
                    err_count_d = err_count_q + 32'd1;
                    load_err_d  = 1'b1;
`endif
                end
                state_d = (idx_q + 32'd1 == count_q) ? S_DRAIN : S_ISSUE;
            end
            S_DRAIN: begin
                if (fifo_cnt_q == '0) begin
                    state_d     = S_DONE;
                    load_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            fifo_x_d[wr_ptr_q]   = bram_dout[31:16];
            fifo_y_d[wr_ptr_q]   = bram_dout[15:0];
            fifo_idx_d[wr_ptr_q] = idx_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            param_done_q <= 1'b0;
            count_q      <= '0;
            idx_q        <= '0;
            bram_addr_q  <= '0;
            bram_ea_q    <= 1'b0;
            wait_q       <= '0;
            load_done_q  <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_x_q[i]   <= '0;
                fifo_y_q[i]   <= '0;
                fifo_idx_q[i] <= '0;
            end
`ifdef SUBSET_BOUNDS_CHECK_EN
            width_q      <= '0;
            height_q     <= '0;
            err_count_q  <= '0;
            load_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            param_done_q <= param_done;
            count_q      <= count_d;
            idx_q        <= idx_d;
            bram_addr_q  <= bram_addr_d;
            bram_ea_q    <= bram_ea_d;
            wait_q       <= wait_d;
            load_done_q  <= load_done_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fifo_x_q     <= fifo_x_d;
            fifo_y_q     <= fifo_y_d;
            fifo_idx_q   <= fifo_idx_d;
`ifdef SUBSET_BOUNDS_CHECK_EN
            width_q      <= width_d;
            height_q     <= height_d;
            err_count_q  <= err_count_d;
            load_err_q   <= load_err_d;
`endif
        end
    end

    assign bram_addr   = bram_addr_q;
    assign bram_ea     = bram_ea_q;
    assign bram_we     = 4'b0000;
    assign coord_valid = (fifo_cnt_q != '0);
    assign coord_x     = fifo_x_q[rd_ptr_q];
    assign coord_y     = fifo_y_q[rd_ptr_q];
    assign coord_idx   = fifo_idx_q[rd_ptr_q];
    assign load_done   = load_done_q;
`ifdef SUBSET_BOUNDS_CHECK_EN
    assign load_err    = load_err_q;
    assign err_count   = err_count_q;
`else
    assign load_err    = 1'b0;
    assign err_count   = '0;
`endif

endmodule

// File: tb/tb_subset_coord_loader.sv
// Bench for subset_coord_loader: BRAM model with 2-clock read latency, a
// table-driven expectation model for the output stream, and per-cycle checks.
module tb_subset_coord_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] idx;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        param_done;
    logic [31:0] num_of_subsets;
    logic [31:0] width_;
    logic [31:0] height_;
    logic [31:0] bram_addr;
    logic        bram_ea;
    logic [3:0]  bram_we;
    logic [31:0] bram_dout = '0;
    logic        coord_valid;
    logic        coord_ready;
    logic [15:0] coord_x;
    logic [15:0] coord_y;
    logic [31:0] coord_idx;
    logic        load_done;
    logic        load_err;
    logic [31:0] err_count;

    logic [31:0] tbl [16];
    ent_t        exp_q [$];
    ent_t        out_log [$];
    int          exp_err;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          last_rd_cyc = 0;
    logic [31:0] first_rd_addr = '0;
    bit          chk_gap = 1'b0;
    bit          ea_prev = 1'b0;
    bit          ea_any = 1'b0;

    subset_coord_loader dut (
        .clk            (clk),
        .rst            (rst),
        .param_done     (param_done),
        .num_of_subsets (num_of_subsets),
        .width_         (width_),
        .height_        (height_),
        .bram_addr      (bram_addr),
        .bram_ea        (bram_ea),
        .bram_we        (bram_we),
        .bram_dout      (bram_dout),
        .coord_valid    (coord_valid),
        .coord_ready    (coord_ready),
        .coord_x        (coord_x),
        .coord_y        (coord_y),
        .coord_idx      (coord_idx),
        .load_done      (load_done),
        .load_err       (load_err),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    // Single-register BRAM: address launched after edge N, data sampled at N+2.
    always @(posedge clk) begin
        if (bram_ea) bram_dout <= tbl[4'((bram_addr - BASE) >> 2)];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle checker: read addresses/spacing and output stream vs model.
    always @(negedge clk) begin
        ent_t e;
        cyc++;
        if (!rst) begin
            chk("bram_we", 32'(bram_we), 32'd0);
            if (bram_ea) ea_any = 1'b1;
            if (bram_ea && !ea_prev) begin
                if (rd_cnt == 0) first_rd_addr = bram_addr;
                chk("rd_addr", bram_addr, BASE + 32'(4 * rd_cnt));
                if (chk_gap && rd_cnt > 0) chk("rd_gap", 32'(cyc - last_rd_cyc), 32'd3);
                last_rd_cyc = cyc;
                rd_cnt++;
            end
            if (coord_valid && coord_ready) begin
                out_log.push_back('{x: coord_x, y: coord_y, idx: coord_idx});
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_output: got idx %0d, expected no output", coord_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("coord_x", 32'(coord_x), 32'(e.x));
                    chk("coord_y", 32'(coord_y), 32'(e.y));
                    chk("coord_idx", coord_idx, e.idx);
                end
            end
        end
        ea_prev = bram_ea;
    end

    // Expected output stream and error count from table, size and bounds.
    task automatic build_model(input int cnt);
        logic [15:0] x, y;
        bit ok;
        exp_q.delete();
        out_log.delete();
        exp_err = 0;
        rd_cnt = 0;
        ea_any = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            x = tbl[i][31:16];
            y = tbl[i][15:0];
`ifdef SUBSET_BOUNDS_CHECK_EN
            ok = (32'(x) < width_) && (32'(y) < height_);
`else
            ok = 1'b1;
`endif
            if (ok) exp_q.push_back('{x: x, y: y, idx: 32'(i)});
            else exp_err++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        param_done = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic setup(input int cnt, input logic [31:0] w, input logic [31:0] h);
        num_of_subsets = 32'(cnt);
        width_ = w;
        height_ = h;
        build_model(cnt);
    endtask

    task automatic start_load();
        @(posedge clk);
        #1 param_done = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!load_done && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!load_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_done_timeout: load_done=%0b after %0d cycles, expected 1", load_done, budget);
        end
    endtask

    task automatic wait_outputs(input int n, input int budget);
        int k = 0;
        while (out_log.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (out_log.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL output_timeout: %0d outputs, expected %0d", out_log.size(), n);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, bram_addr, 32'd0);
        chk({tag, "_ea"}, 32'(bram_ea), 32'd0);
        chk({tag, "_we"}, 32'(bram_we), 32'd0);
        chk({tag, "_valid"}, 32'(coord_valid), 32'd0);
        chk({tag, "_x"}, 32'(coord_x), 32'd0);
        chk({tag, "_y"}, 32'(coord_y), 32'd0);
        chk({tag, "_idx"}, coord_idx, 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(load_err), 32'd0);
        chk({tag, "_errcnt"}, err_count, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        param_done = 1'b0;
        coord_ready = 1'b1;
        num_of_subsets = '0;
        width_ = '0;
        height_ = '0;
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        rst = 1'b0;

        // Nominal: three in-range entries, free-flowing consumer.
        do_reset();
        tbl[0] = {16'd10, 16'd20};
        tbl[1] = {16'd100, 16'd200};
        tbl[2] = {16'd639, 16'd479};
        setup(3, 32'd640, 32'd480);
        chk_gap = 1'b1;
        start_load();
        wait_done(200);
        chk("nom_reads", 32'(rd_cnt), 32'd3);
        chk("nom_first_addr", first_rd_addr, 32'h0000_0100);
        chk("nom_outputs", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            chk("nom_out0", {out_log[0].x, out_log[0].y}, {16'd10, 16'd20});
            chk("nom_out2", {out_log[2].x, out_log[2].y}, {16'd639, 16'd479});
            chk("nom_idx2", out_log[2].idx, 32'd2);
        end
        chk("nom_errcnt", err_count, 32'd0);
        chk("nom_loaderr", 32'(load_err), 32'd0);
        repeat (20) @(posedge clk);
        #1 chk("nom_no_restart", 32'(rd_cnt), 32'd3);
        chk("nom_done_sticky", 32'(load_done), 32'd1);
        chk_gap = 1'b0;

        // Zero count: done one clock after the rise, no BRAM access.
        do_reset();
        setup(0, 32'd640, 32'd480);
        start_load();
        chk("zero_done_before", 32'(load_done), 32'd0);
        @(posedge clk);
        #1 chk("zero_done_next", 32'(load_done), 32'd1);
        repeat (10) @(posedge clk);
        #1 chk("zero_no_ea", 32'(ea_any), 32'd0);
        chk("zero_reads", 32'(rd_cnt), 32'd0);

        // Bounds: x==width and y==height are out of range, (7,7) is in.
        do_reset();
        tbl[0] = {16'd640, 16'd5};
        tbl[1] = {16'd3, 16'd480};
        tbl[2] = {16'd7, 16'd7};
        setup(3, 32'd640, 32'd480);
        start_load();
        wait_done(200);
        chk("bnd_errcnt", err_count, 32'(exp_err));
        chk("bnd_loaderr", 32'(load_err), 32'(exp_err != 0));
        chk("bnd_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef SUBSET_BOUNDS_CHECK_EN
        chk("bnd_outputs", 32'(out_log.size()), 32'd1);
        chk("bnd_errcnt_lit", err_count, 32'd2);
        if (out_log.size() == 1) begin
            chk("bnd_idx", out_log[0].idx, 32'd2);
            chk("bnd_xy", {out_log[0].x, out_log[0].y}, {16'd7, 16'd7});
        end
`else
        chk("nochk_outputs", 32'(out_log.size()), 32'd3);
        chk("nochk_errcnt_lit", err_count, 32'd0);
        if (out_log.size() == 3) chk("nochk_x640", 32'(out_log[0].x), 32'd640);
`endif

        // Back-pressure: consumer stalled, FIFO fills after 8 reads.
        do_reset();
        for (int i = 0; i < 12; i++) tbl[i] = {16'(i + 1), 16'(2 * i + 3)};
        setup(12, 32'd640, 32'd480);
        coord_ready = 1'b0;
        start_load();
        repeat (80) @(posedge clk);
        #1 chk("bp_reads_stalled", 32'(rd_cnt), 32'd8);
        chk("bp_ea_low", 32'(bram_ea), 32'd0);
        chk("bp_valid", 32'(coord_valid), 32'd1);
        chk("bp_head_idx", coord_idx, 32'd0);
        coord_ready = 1'b1;
        wait_done(400);
        chk("bp_reads", 32'(rd_cnt), 32'd12);
        chk("bp_outputs", 32'(out_log.size()), 32'd12);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        if (out_log.size() == 12) chk("bp_last_idx", out_log[11].idx, 32'd11);

        // Reset mid-load: outputs clear at once, restart from entry 0.
        do_reset();
        setup(12, 32'd640, 32'd480);
        start_load();
        wait_outputs(5, 200);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        param_done = 1'b0;
        first_rd_addr = '0;
        build_model(12);
        @(posedge clk);
        #1 rst = 1'b0;
        start_load();
        wait_done(400);
        chk("rst_first_addr", first_rd_addr, 32'h0000_0100);
        chk("rst_reads", 32'(rd_cnt), 32'd12);
        chk("rst_outputs", 32'(out_log.size()), 32'd12);
        if (out_log.size() == 12) chk("rst_first_idx", out_log[0].idx, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
